// File: rtl/huffman_encoder.sv
// Streaming Huffman encoder: packs variable-length codes for 4-bit symbols
// into bytes, MSB first, with an explicit flush that emits a zero-padded last byte.
module huffman_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [3:0] sym_data,
  output logic       sym_ready,
  input  logic       flush,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err,
  output logic       flush_done
);

  typedef enum logic [1:0] {ACCEPT, EMIT, FLUSH} state_t;

  state_t      state, state_nx;
  logic [13:0] acc, acc_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        flush_pend, flush_pend_nx;
  logic        err_q, err_nx;
  logic        flush_done_q, flush_done_nx;

  logic [2:0]  code_len;
  logic [5:0]  code_bits;   // code left-aligned in 6 bits
  logic        code_ok;
  logic [3:0]  cnt_sum;
  logic        accept;

  always_comb begin
    code_ok   = 1'b1;
    code_len  = 3'd0;
    code_bits = 6'b000000;
    case (sym_data)
      4'd0:  begin code_len = 3'd1; code_bits = 6'b100000; end
      4'd1:  begin code_len = 3'd4; code_bits = 6'b010000; end
      4'd2:  begin code_len = 3'd4; code_bits = 6'b010100; end
      4'd5:  begin code_len = 3'd4; code_bits = 6'b001000; end
      4'd6:  begin code_len = 3'd4; code_bits = 6'b001100; end
      4'd9:  begin code_len = 3'd4; code_bits = 6'b011100; end
      4'd10: begin code_len = 3'd4; code_bits = 6'b000000; end
      4'd7:  begin code_len = 3'd5; code_bits = 6'b011010; end
      4'd3:  begin code_len = 3'd6; code_bits = 6'b011000; end
      4'd4:  begin code_len = 3'd6; code_bits = 6'b011001; end
      4'd8:  begin code_len = 3'd6; code_bits = 6'b000110; end
      4'd12: begin code_len = 3'd6; code_bits = 6'b000111; end
      4'd14: begin code_len = 3'd6; code_bits = 6'b000100; end
      4'd15: begin code_len = 3'd6; code_bits = 6'b000101; end
      default: code_ok = 1'b0;
    endcase
  end

  // cnt never exceeds 7 while accepting, so cnt_sum tops out at 13.
  assign cnt_sum   = cnt + {1'b0, code_len};
  assign sym_ready = rst && (state == ACCEPT) && !cnt[3] && !flush_pend;
  assign accept    = sym_valid && sym_ready;

  assign out_valid  = rst && ((state == EMIT) || (state == FLUSH));
  assign out_last   = rst && (state == FLUSH);
  assign out_data   = out_valid ? acc[13:6] : 8'h00;
  assign err        = rst && err_q;
  assign flush_done = rst && flush_done_q;

  always_comb begin
    state_nx      = state;
    acc_nx        = acc;
    cnt_nx        = cnt;
    flush_pend_nx = flush_pend | flush;
    err_nx        = 1'b0;
    flush_done_nx = 1'b0;
    case (state)
      ACCEPT: begin
        if (flush_pend) begin
          if (cnt != 4'd0) begin
            state_nx = FLUSH;
          end else begin
            flush_pend_nx = flush;
            flush_done_nx = 1'b1;
          end
        end else if (accept) begin
          if (!code_ok) begin
            err_nx = 1'b1;
          end else begin
            acc_nx = acc | ({code_bits, 8'h00} >> cnt);
            cnt_nx = cnt_sum;
            if (cnt_sum >= 4'd8) state_nx = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          acc_nx   = {acc[5:0], 8'h00};
          cnt_nx   = cnt - 4'd8;
          state_nx = ACCEPT;
        end
      end
      FLUSH: begin
        if (out_ready) begin
          acc_nx        = 14'd0;
          cnt_nx        = 4'd0;
          flush_pend_nx = flush;
          flush_done_nx = 1'b1;
          state_nx      = ACCEPT;
        end
      end
      default: state_nx = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ACCEPT;
      acc          <= 14'd0;
      cnt          <= 4'd0;
      flush_pend   <= 1'b0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state        <= state_nx;
      acc          <= acc_nx;
      cnt          <= cnt_nx;
      flush_pend   <= flush_pend_nx;
      err_q        <= err_nx;
      flush_done_q <= flush_done_nx;
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: directed scenarios plus a random
// symbol stream checked against an independent bit-level packing model.
module tb_huffman_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sym_valid = 1'b0;
  logic [3:0] sym_data = 4'd0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;
  logic       sym_ready, out_valid, out_last, err, flush_done;
  logic [7:0] out_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int errs = 0;
  int fdones = 0;

  logic [8:0] obs[$];
  logic [8:0] exp_q[$];
  bit         mq[$];

  huffman_encoder dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .err(err), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  // Byte taken at the next rising edge when valid and ready at the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) obs.push_back({out_last, out_data});
    if (err) errs++;
    if (flush_done) fdones++;
  end

  task automatic send_sym(input logic [3:0] s);
    int n;
    sym_valid = 1'b1;
    sym_data  = s;
    n = 0;
    @(negedge clk);
    while (!sym_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sym_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout sym=%0d sym_ready=0 required 1", s);
    end
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_code(input int s, output int len, output int bits);
    case (s)
      0:  begin len = 1; bits = 'b1;      end
      1:  begin len = 4; bits = 'b0100;   end
      2:  begin len = 4; bits = 'b0101;   end
      5:  begin len = 4; bits = 'b0010;   end
      6:  begin len = 4; bits = 'b0011;   end
      9:  begin len = 4; bits = 'b0111;   end
      10: begin len = 4; bits = 'b0000;   end
      7:  begin len = 5; bits = 'b01101;  end
      3:  begin len = 6; bits = 'b011000; end
      4:  begin len = 6; bits = 'b011001; end
      8:  begin len = 6; bits = 'b000110; end
      12: begin len = 6; bits = 'b000111; end
      14: begin len = 6; bits = 'b000100; end
      15: begin len = 6; bits = 'b000101; end
      default: begin len = 0; bits = 0; end
    endcase
  endtask

  task automatic model_pop_byte(input bit last);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], mq.pop_front()};
    exp_q.push_back({last, b});
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00)   begin bad++; $display("FAIL rst_out_data got %h want 00", out_data); end
    total++; if (out_last !== 1'b0)    begin bad++; $display("FAIL rst_out_last got %b want 0", out_last); end
    total++; if (sym_ready !== 1'b0)   begin bad++; $display("FAIL rst_sym_ready got %b want 0", sym_ready); end
    total++; if (err !== 1'b0)         begin bad++; $display("FAIL rst_err got %b want 0", err); end
    total++; if (flush_done !== 1'b0)  begin bad++; $display("FAIL rst_flush_done got %b want 0", flush_done); end
    @(posedge clk); #1;
    rst = 1'b1;
    settle(2);
  endtask

  task automatic test_back_to_back();
    int c0, f0;
    logic [8:0] e, o;
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_sym(4'd0);
    total++; if (cyc - c0 != 8) begin bad++; $display("FAIL b2b_cycles got %0d want 8", cyc - c0); end
    exp_q.push_back(9'h0FF);
    settle(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs.size() == 0) begin bad++; $display("FAIL b2b_byte got none want %h", e); end
      else begin o = obs.pop_front(); if (o !== e) begin bad++; $display("FAIL b2b_byte got %h want %h", o, e); end end
    end
    // flush with nothing pending proves cnt returned to 0
    f0 = fdones;
    pulse_flush();
    settle(5);
    total++; if (fdones != f0 + 1) begin bad++; $display("FAIL b2b_cnt0_flush_done got %0d want %0d", fdones - f0, 1); end
    total++; if (obs.size() != 0) begin bad++; $display("FAIL b2b_cnt0_no_byte got %0d bytes want 0", obs.size()); end
    obs.delete();
  endtask

  task automatic test_pair();
    logic [8:0] o;
    send_sym(4'd9);
    send_sym(4'd2);
    settle(8);
    total++;
    if (obs.size() != 1) begin bad++; $display("FAIL pair_count got %0d want 1", obs.size()); end
    else begin o = obs.pop_front(); if (o !== 9'h075) begin bad++; $display("FAIL pair_byte got %h want 075", o); end end
    obs.delete();
  endtask

  task automatic test_flush();
    int f0, e0;
    logic [8:0] e, o;
    f0 = fdones;
    e0 = errs;
    send_sym(4'd3);
    send_sym(4'd8);
    pulse_flush();
    exp_q.push_back(9'h060);
    exp_q.push_back(9'h160);
    settle(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs.size() == 0) begin bad++; $display("FAIL flush_byte got none want %h", e); end
      else begin o = obs.pop_front(); if (o !== e) begin bad++; $display("FAIL flush_byte got %h want %h", o, e); end end
    end
    total++; if (obs.size() != 0) begin bad++; $display("FAIL flush_extra got %0d bytes want 0", obs.size()); end
    total++; if (fdones != f0 + 1) begin bad++; $display("FAIL flush_done_count got %0d want 1", fdones - f0); end
    total++; if (errs != e0) begin bad++; $display("FAIL flush_err got %0d want 0", errs - e0); end
    obs.delete();
  endtask

  task automatic test_err();
    int f0, e0;
    logic [8:0] o;
    f0 = fdones;
    e0 = errs;
    send_sym(4'd11);
    settle(3);
    total++; if (errs != e0 + 1) begin bad++; $display("FAIL err_pulse got %0d want 1", errs - e0); end
    total++; if (obs.size() != 0) begin bad++; $display("FAIL err_no_byte got %0d want 0", obs.size()); end
    pulse_flush();
    settle(5);
    total++; if (fdones != f0 + 1) begin bad++; $display("FAIL err_flush_done got %0d want 1", fdones - f0); end
    total++; if (obs.size() != 0) begin bad++; $display("FAIL err_flush_no_byte got %0d want 0", obs.size()); end
    // dropped symbol must leave alignment untouched
    send_sym(4'd13);
    for (int i = 0; i < 8; i++) send_sym(4'd0);
    settle(8);
    total++;
    if (obs.size() != 1) begin bad++; $display("FAIL err_align_count got %0d want 1", obs.size()); end
    else begin o = obs.pop_front(); if (o !== 9'h0FF) begin bad++; $display("FAIL err_align_byte got %h want 0FF", o); end end
    obs.delete();
  endtask

  task automatic test_stall();
    int n;
    logic [8:0] o;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_sym(4'd0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got %b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_data !== 8'hFF || out_valid !== 1'b1 || out_last !== 1'b0 || sym_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cycle=%0d got data=%h v=%b l=%b rdy=%b want FF 1 0 0", i, out_data, out_valid, out_last, sym_ready);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    settle(5);
    total++;
    if (obs.size() != 1) begin bad++; $display("FAIL stall_release_count got %0d want 1", obs.size()); end
    else begin o = obs.pop_front(); if (o !== 9'h0FF) begin bad++; $display("FAIL stall_release_byte got %h want 0FF", o); end end
    obs.delete();
  endtask

  task automatic test_reset_mid();
    int f0;
    logic [8:0] o;
    out_ready = 1'b0;
    send_sym(4'd0);
    send_sym(4'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
        sym_ready !== 1'b0 || err !== 1'b0 || flush_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs got v=%b d=%h l=%b rdy=%b e=%b fd=%b want all 0",
               out_valid, out_data, out_last, sym_ready, err, flush_done);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || sym_ready !== 1'b0) begin bad++; $display("FAIL midrst_held got v=%b rdy=%b want 0 0", out_valid, sym_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    f0 = fdones;
    settle(10);
    total++; if (obs.size() != 0) begin bad++; $display("FAIL midrst_no_byte got %0d want 0", obs.size()); end
    total++; if (fdones != f0) begin bad++; $display("FAIL midrst_no_flush_done got %0d want 0", fdones - f0); end
    obs.delete();
    for (int i = 0; i < 8; i++) send_sym(4'd0);
    settle(8);
    total++;
    if (obs.size() != 1) begin bad++; $display("FAIL midrst_after_count got %0d want 1", obs.size()); end
    else begin o = obs.pop_front(); if (o !== 9'h0FF) begin bad++; $display("FAIL midrst_after_byte got %h want 0FF", o); end end
    obs.delete();
  endtask

  task automatic test_random();
    int s, len, bits, e0, nerr;
    logic [8:0] e, o;
    e0 = errs;
    nerr = 0;
    mq.delete();
    for (int k = 0; k < 40; k++) begin
      s = int'($urandom_range(0, 15));
      send_sym(s[3:0]);
      model_code(s, len, bits);
      if (len == 0) nerr++;
      for (int b = len - 1; b >= 0; b--) mq.push_back(bit'((bits >> b) & 1));
      while (mq.size() >= 8) model_pop_byte(1'b0);
    end
    pulse_flush();
    if (mq.size() > 0) begin
      while (mq.size() < 8) mq.push_back(1'b0);
      model_pop_byte(1'b1);
    end
    settle(30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs.size() == 0) begin bad++; $display("FAIL rand_byte got none want %h", e); end
      else begin o = obs.pop_front(); if (o !== e) begin bad++; $display("FAIL rand_byte got %h want %h", o, e); end end
    end
    total++; if (obs.size() != 0) begin bad++; $display("FAIL rand_extra got %0d bytes want 0", obs.size()); end
    total++; if (errs - e0 != nerr) begin bad++; $display("FAIL rand_err_count got %0d want %0d", errs - e0, nerr); end
    obs.delete();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_pair();
    test_flush();
    test_err();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huffman_encoder.md
HUFFMAN_ENCODER -- requirements
Module: huffman_encoder

Interface
REQ-001 SHALL: clk  input  1  clock; all state changes on its rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL: sym_valid  input  1  upstream symbol present.
REQ-004 SHALL: sym_data  input  4  symbol to encode (0-15).
REQ-005 SHALL: sym_ready  output  1  symbol accepted on the clk edge where sym_valid && sym_ready.
REQ-006 SHALL: flush  input  1  one-cycle pulse requesting that pending partial bits be emitted.
REQ-007 SHALL: out_valid  output  1  out_data/out_last valid.
REQ-008 SHALL: out_data  output  8  packed bitstream byte, first code bit in bit 7.
REQ-009 SHALL: out_last  output  1  current byte is the zero-padded flush byte.
REQ-010 SHALL: out_ready  input  1  downstream takes the byte on the clk edge where out_valid && out_ready.
REQ-011 SHALL: err  output  1  one-cycle pulse, unencodable symbol dropped.
REQ-012 SHALL: flush_done  output  1  one-cycle pulse, flush complete.

Function
REQ-013 SHALL use code table (symbol:code, MSB first): 0:1; 1:0100; 2:0101; 5:0010; 6:0011; 9:0111; 10:0000; 7:01101; 3:011000; 4:011001; 8:000110; 12:000111; 14:000100; 15:000101.
REQ-014 SHALL treat symbols 11 and 13 as unencodable: on acceptance, err pulses the following cycle, no bits appended, cnt unchanged.
REQ-015 SHALL hold a 14-bit left-aligned accumulator acc and a 4-bit bit count cnt (0..13).
REQ-016 SHALL implement states ACCEPT, EMIT, FLUSH.
REQ-017 SHALL drive sym_ready=1 only in ACCEPT with cnt<8 and flush_pend=0.
REQ-018 SHALL, on accept of an encodable symbol of length L, append the code directly after the existing cnt bits; cnt <= cnt+L; go to EMIT if cnt+L>=8, else stay in ACCEPT.
REQ-019 SHALL, in EMIT, drive out_valid=1, out_data=acc[13:6], out_last=0; on handshake shift acc left 8 (zero fill), cnt <= cnt-8, return to ACCEPT.
REQ-020 SHALL register a flush pulse into flush_pend in any state; a flush coinciding with a symbol accept SHALL still include that symbol in the flush.
REQ-021 SHALL, in ACCEPT with flush_pend=1: if cnt>0 go to FLUSH; if cnt=0 clear flush_pend and pulse flush_done the next cycle with no output byte.
REQ-022 SHALL, in FLUSH, drive out_valid=1, out_data=acc[13:6] (bits beyond cnt are 0), out_last=1; on handshake clear acc, cnt and flush_pend, pulse flush_done, return to ACCEPT.
REQ-023 SHALL hold out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL raise out_valid in the cycle after the accepting edge that completes a byte (1-cycle latency).
REQ-025 SHALL sustain one accepted symbol per cycle while no byte is completed.

Reset
REQ-026 SHALL, while rst=0 at an edge, set state=ACCEPT, acc=0, cnt=0, flush_pend=0, out_valid=0, out_last=0, out_data=0x00, err=0, flush_done=0, sym_ready=0 for that cycle.
REQ-027 SHALL discard all pending bits and any in-flight byte on reset mid-operation; no byte is emitted after reset release until new symbols arrive.

Verification
REQ-028 SHALL cover: eight symbols 0 back-to-back -> one byte 0xFF, out_last=0, cnt=0 afterwards.
REQ-029 SHALL cover: symbols 9 then 2 -> byte 0x75.
REQ-030 SHALL cover: symbols 3, 8, then flush -> bytes 0x60 (out_last=0) then 0x60 (out_last=1), then flush_done pulse.
REQ-031 SHALL cover: symbol 11, then flush with cnt=0 -> err pulse, no byte, flush_done pulse.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles during EMIT -> out_data stable, sym_ready=0 throughout, byte taken on release.
REQ-033 SHALL cover: rst=0 asserted with cnt=5 and flush_pend=1 -> all outputs at reset values; post-release symbol 0 x8 -> 0xFF.
